// File: rtl/hp_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hp_pkg
// Purpose  : Shared constants for the HP arbiter block: HP width, default
//            starting HP, FSM state encoding, player indices and the
//            saturating subtract used by the damage datapath.
// Revision : 1.0  initial release
// ============================================================================
package hp_pkg;

  localparam int c_hp_w       = 8;
  localparam int c_max_hp_def = 100;

  // FSM state encoding
  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_active = 2'd1;
  localparam logic [1:0] c_st_ko     = 2'd2;

  // Player indices (also bit positions in req/grant/ack/ko vectors)
  localparam logic c_p1 = 1'b0;
  localparam logic c_p2 = 1'b1;

  // HP' = (HP > dmg) ? HP - dmg : 0
  function automatic logic [c_hp_w-1:0] sat_sub(input logic [c_hp_w-1:0] hp,
                                                input logic [c_hp_w-1:0] dmg);
    return (hp > dmg) ? (hp - dmg) : '0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hp_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : hp_arbiter_if
// Purpose  : Hit-request bus between the two player front-ends and the HP
//            arbiter.
// Ports    : round_start, game_active         - round/game control
//            pN_hit_req / pN_hit_dmg          - held-until-acked hit request
//            pN_hit_ack                       - one-cycle consume pulse
//            p1HP / p2HP / ko                 - arbiter status outputs
//            modport slave  : arbiter side
//            modport master : requester / game-control side
// Revision : 1.0  initial release
// ============================================================================
interface hp_arbiter_if;
  import hp_pkg::*;

  logic              round_start;
  logic              game_active;
  logic              p1_hit_req;
  logic [c_hp_w-1:0] p1_hit_dmg;
  logic              p2_hit_req;
  logic [c_hp_w-1:0] p2_hit_dmg;
  logic              p1_hit_ack;
  logic              p2_hit_ack;
  logic [c_hp_w-1:0] p1HP;
  logic [c_hp_w-1:0] p2HP;
  logic [1:0]        ko;

  modport slave (
    input  round_start, game_active,
    input  p1_hit_req, p1_hit_dmg, p2_hit_req, p2_hit_dmg,
    output p1_hit_ack, p2_hit_ack, p1HP, p2HP, ko
  );

  modport master (
    output round_start, game_active,
    output p1_hit_req, p1_hit_dmg, p2_hit_req, p2_hit_dmg,
    input  p1_hit_ack, p2_hit_ack, p1HP, p2HP, ko
  );

endinterface
`default_nettype wire

// File: rtl/hp_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Purpose  : Two-way round-robin grant. A lone request is granted directly;
//            on contention the player not granted last wins.
// Ports    : req[1:0]   - requests (bit0 = p1, bit1 = p2)
//            last       - index of the player granted most recently
//            grant[1:0] - one-hot (or zero) grant, combinational
// Revision : 1.0  initial release
// ============================================================================
module rr_arb2
  import hp_pkg::*;
(
  input  wire logic [1:0] req,
  input  wire logic       last,
  output logic      [1:0] grant
);

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = (last == c_p2) ? 2'b01 : 2'b10;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hp_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : hp_arbiter
// Purpose  : Two-player hit-point arbiter. Grants at most one pending hit per
//            cycle through a single saturating subtractor, tracks knock-outs
//            and sequences IDLE -> ACTIVE -> KO rounds.
// Ports    : clk    - system clock, rising edge
//            rst_n  - asynchronous active-low reset
//            bus    - hp_arbiter_if.slave (requests, acks, HP, ko)
// Config   : HP_ARB_INVULN_EN - when defined, a defender becomes invulnerable
//            for INVULN_CYCLES cycles after taking nonzero damage.
// Revision : 1.0  initial release
// ============================================================================
module hp_arbiter
  import hp_pkg::*;
#(
  parameter int MAX_HP        = c_max_hp_def,
  parameter int INVULN_CYCLES = 8
) (
  input  wire logic    clk,
  input  wire logic    rst_n,
  hp_arbiter_if.slave  bus
);

  localparam logic [c_hp_w-1:0] c_max_hp = c_hp_w'(MAX_HP);

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [c_hp_w-1:0] r_hp [2];
  logic [1:0]        r_ack;
  logic [1:0]        r_ko;
  logic              r_last;

  logic              w_grant_en;
  logic [1:0]        w_req;
  logic [1:0]        w_grant;
  logic              w_hit;
  logic              w_att;
  logic              w_def;
  logic [c_hp_w-1:0] w_dmg;
  logic [c_hp_w-1:0] w_hp_new;
  logic              w_blocked;
  logic              w_kill;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_st_idle;
    else        r_state <= w_state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle:   if (bus.round_start) w_state_nxt = c_st_active;
      c_st_active: begin
        if (bus.round_start) w_state_nxt = c_st_active;
        else if (w_kill)     w_state_nxt = c_st_ko;
      end
      c_st_ko:     if (bus.round_start) w_state_nxt = c_st_active;
      default:     w_state_nxt = c_st_idle;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    w_grant_en = (r_state == c_st_active) && bus.game_active && !bus.round_start;
  end

  // A request whose ack is currently high has just been consumed; masking it
  // keeps the same request from being granted twice before the requester
  // sees the ack and drops it.
  assign w_req = {bus.p2_hit_req & ~r_ack[1], bus.p1_hit_req & ~r_ack[0]}
                 & {2{w_grant_en}};

  rr_arb2 u_rr (
    .req   (w_req),
    .last  (r_last),
    .grant (w_grant)
  );

  // Shared subtractor: the attacker's damage applied to the other player.
  assign w_hit    = |w_grant;
  assign w_att    = w_grant[1] ? c_p2 : c_p1;
  assign w_def    = ~w_att;
  assign w_dmg    = (w_att == c_p2) ? bus.p2_hit_dmg : bus.p1_hit_dmg;
  assign w_hp_new = w_blocked ? r_hp[w_def] : sat_sub(r_hp[w_def], w_dmg);
  assign w_kill   = w_hit && (w_hp_new == '0);

`ifdef HP_ARB_INVULN_EN
  logic [7:0] r_tmr [2];
  localparam logic [7:0] c_invuln = 8'(INVULN_CYCLES);

  assign w_blocked = (r_tmr[w_def] != 8'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmr[0] <= 8'd0;
      r_tmr[1] <= 8'd0;
    end else if (bus.round_start) begin
      r_tmr[0] <= 8'd0;
      r_tmr[1] <= 8'd0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        // Only a hit that actually lands with nonzero damage (re)arms the
        // window; blocked hits and zero-damage hits leave it running.
        if (w_hit && (w_def == 1'(i)) && !w_blocked && (w_dmg != '0))
          r_tmr[i] <= c_invuln;
        else if (r_tmr[i] != 8'd0)
          r_tmr[i] <= r_tmr[i] - 8'd1;
      end
    end
  end
`else
  assign w_blocked = 1'b0;
`endif

  // ---------------- HP / ack / ko datapath ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hp[0] <= c_max_hp;
      r_hp[1] <= c_max_hp;
      r_ack   <= 2'b00;
      r_ko    <= 2'b00;
      r_last  <= c_p2;        // so p1 wins the first contention
    end else if (bus.round_start) begin
      r_hp[0] <= c_max_hp;
      r_hp[1] <= c_max_hp;
      r_ack   <= 2'b00;
      r_ko    <= 2'b00;
    end else begin
      r_ack <= w_grant;
      if (w_hit) begin
        r_hp[w_def] <= w_hp_new;
        r_last      <= w_att;
        if (w_kill) r_ko[w_def] <= 1'b1;
      end
    end
  end

  assign bus.p1_hit_ack = r_ack[0];
  assign bus.p2_hit_ack = r_ack[1];
  assign bus.p1HP       = r_hp[0];
  assign bus.p2HP       = r_hp[1];
  assign bus.ko         = r_ko;

endmodule
`default_nettype wire

// File: tb/tb_hp_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_hp_arbiter
// Purpose  : Self-checking bench for hp_arbiter: directed round scenarios
//            followed by randomized requesters, all compared cycle by cycle
//            against a behavioural model of the game rules.
// Config   : HP_ARB_INVULN_EN enables the invulnerability scenario and model.
// Revision : 1.0  initial release
// ============================================================================
module tb_hp_arbiter;

  localparam int MAX_HP  = 100;
  localparam int INV_CYC = 8;
`ifdef HP_ARB_INVULN_EN
  localparam bit INV_ON = 1'b1;
`else
  localparam bit INV_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hp_arbiter_if bus();

  hp_arbiter #(.MAX_HP(MAX_HP), .INVULN_CYCLES(INV_CYC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_pass = 0;
  int n_chk  = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  // ---------------- behavioural model ----------------
  int m_hp [2];
  int m_tmr[2];
  int m_ko;        // bit0 = p1 out, bit1 = p2 out
  bit m_run;       // a round is in progress and nobody is out
  int m_last;      // player granted most recently
  bit m_ack[2];

  function automatic void model_reset();
    m_hp[0] = MAX_HP; m_hp[1] = MAX_HP;
    m_tmr[0] = 0;     m_tmr[1] = 0;
    m_ko = 0; m_run = 1'b0; m_last = 1;
    m_ack[0] = 1'b0;  m_ack[1] = 1'b0;
  endfunction

  // Predicts the effect of the coming rising edge from the current inputs.
  function automatic void model_edge();
    bit req[2];
    int dmg[2];
    bit elig[2];
    int nt[2];
    int win, def;
    req[0] = bus.p1_hit_req; dmg[0] = int'(bus.p1_hit_dmg);
    req[1] = bus.p2_hit_req; dmg[1] = int'(bus.p2_hit_dmg);
    if (bus.round_start) begin
      m_hp[0] = MAX_HP; m_hp[1] = MAX_HP;
      m_tmr[0] = 0; m_tmr[1] = 0;
      m_ko = 0; m_run = 1'b1;
      m_ack[0] = 1'b0; m_ack[1] = 1'b0;
      return;
    end
    for (int i = 0; i < 2; i++) begin
      elig[i] = req[i] && !m_ack[i];
      nt[i]   = (m_tmr[i] > 0) ? m_tmr[i] - 1 : 0;
    end
    m_ack[0] = 1'b0; m_ack[1] = 1'b0;
    win = -1;
    if (m_run && bus.game_active) begin
      if (elig[0] && elig[1]) win = 1 - m_last;
      else if (elig[0])       win = 0;
      else if (elig[1])       win = 1;
    end
    if (win >= 0) begin
      def = 1 - win;
      if (!(INV_ON && m_tmr[def] > 0)) begin
        m_hp[def] = (dmg[win] >= m_hp[def]) ? 0 : m_hp[def] - dmg[win];
        if (INV_ON && dmg[win] > 0) nt[def] = INV_CYC;
        if (m_hp[def] == 0) begin
          m_ko  = m_ko | (1 << def);
          m_run = 1'b0;
        end
      end
      m_ack[win] = 1'b1;
      m_last     = win;
    end
    m_tmr[0] = nt[0]; m_tmr[1] = nt[1];
  endfunction

  // One clock: predict, advance, sample #1 after the edge, compare.
  task automatic cycle(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check({tag, "/p1_ack"}, int'(bus.p1_hit_ack), int'(m_ack[0]));
    check({tag, "/p2_ack"}, int'(bus.p2_hit_ack), int'(m_ack[1]));
    check({tag, "/p1HP"},   int'(bus.p1HP),       m_hp[0]);
    check({tag, "/p2HP"},   int'(bus.p2HP),       m_hp[1]);
    check({tag, "/ko"},     int'(bus.ko),         m_ko);
  endtask

  task automatic set_req(input int p, input bit r, input int d);
    if (p == 0) begin bus.p1_hit_req = r; bus.p1_hit_dmg = 8'(d); end
    else        begin bus.p2_hit_req = r; bus.p2_hit_dmg = 8'(d); end
  endtask

  task automatic start_round();
    bus.round_start = 1'b1;
    cycle("round_start");
    bus.round_start = 1'b0;
  endtask

  int d;
  bit r;

  initial begin
    rst_n = 1'b0;
    bus.round_start = 1'b0;
    bus.game_active = 1'b0;
    set_req(0, 1'b0, 0);
    set_req(1, 1'b0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst/p1HP", int'(bus.p1HP), MAX_HP);
    check("rst/p2HP", int'(bus.p2HP), MAX_HP);
    check("rst/ko",   int'(bus.ko), 0);
    check("rst/acks", int'({bus.p2_hit_ack, bus.p1_hit_ack}), 0);
    rst_n = 1'b1;

    // IDLE: a pending request must stall
    bus.game_active = 1'b1;
    set_req(0, 1'b1, 10);
    repeat (3) cycle("idle_stall");
    check("idle/p1_ack", int'(bus.p1_hit_ack), 0);
    set_req(0, 1'b0, 0);

    // Round start and simultaneous contention
    start_round();
    check("start/p1HP", int'(bus.p1HP), 100);
    check("start/p2HP", int'(bus.p2HP), 100);
    check("start/ko",   int'(bus.ko), 0);
    set_req(0, 1'b1, 10);
    set_req(1, 1'b1, 10);
    cycle("contend1");
    check("contend1/p1_ack", int'(bus.p1_hit_ack), 1);
    check("contend1/p2HP",   int'(bus.p2HP), 90);
    set_req(0, 1'b0, 0);
    cycle("contend2");
    check("contend2/p2_ack", int'(bus.p2_hit_ack), 1);
    check("contend2/p1HP",   int'(bus.p1HP), 90);
    set_req(1, 1'b0, 0);
    cycle("contend_idle");

    // Knock-out with saturation, then requests stall in KO
    start_round();
    set_req(0, 1'b1, 95);
    cycle("to5");
    check("to5/p2HP", int'(bus.p2HP), 5);
    set_req(0, 1'b0, 0);
    repeat (INV_CYC + 2) cycle("to5_gap");
    set_req(0, 1'b1, 20);
    cycle("kill");
    check("kill/p2HP", int'(bus.p2HP), 0);
    check("kill/ko",   int'(bus.ko), 2);
    set_req(0, 1'b0, 0);
    set_req(1, 1'b1, 30);
    repeat (5) begin
      cycle("ko_stall");
      check("ko_stall/p2_ack", int'(bus.p2_hit_ack), 0);
    end
    set_req(1, 1'b0, 0);

    // game_active low stalls; high again services next cycle
    start_round();
    bus.game_active = 1'b0;
    set_req(0, 1'b1, 7);
    repeat (5) begin
      cycle("ga_low");
      check("ga_low/p1_ack", int'(bus.p1_hit_ack), 0);
      check("ga_low/p2HP",   int'(bus.p2HP), 100);
    end
    bus.game_active = 1'b1;
    cycle("ga_high");
    check("ga_high/p1_ack", int'(bus.p1_hit_ack), 1);
    check("ga_high/p2HP",   int'(bus.p2HP), 93);
    set_req(0, 1'b0, 0);
    cycle("ga_idle");

    // round_start coincident with a pending hit
    set_req(0, 1'b1, 5);
    bus.round_start = 1'b1;
    cycle("rs_pend");
    check("rs_pend/p1_ack", int'(bus.p1_hit_ack), 0);
    check("rs_pend/p2HP",   int'(bus.p2HP), 100);
    bus.round_start = 1'b0;
    cycle("rs_next");
    check("rs_next/p1_ack", int'(bus.p1_hit_ack), 1);
    check("rs_next/p2HP",   int'(bus.p2HP), 95);
    set_req(0, 1'b0, 0);
    cycle("rs_idle");

    // Zero damage: acked, HP unchanged
    set_req(1, 1'b1, 0);
    cycle("zero");
    check("zero/p2_ack", int'(bus.p2_hit_ack), 1);
    check("zero/p1HP",   int'(bus.p1HP), 100);
    set_req(1, 1'b0, 0);
    cycle("zero_idle");

`ifdef HP_ARB_INVULN_EN
    // Grants on edges 0, 3 and 10: only 0 and 10 land
    start_round();
    for (int e = 0; e <= 10; e++) begin
      set_req(0, (e == 0 || e == 3 || e == 10), 10);
      cycle("inv");
      if (e == 0)  check("inv0/p2HP", int'(bus.p2HP), 90);
      if (e == 3) begin
        check("inv3/p1_ack", int'(bus.p1_hit_ack), 1);
        check("inv3/p2HP",   int'(bus.p2HP), 90);
      end
      if (e == 10) check("inv10/p2HP", int'(bus.p2HP), 80);
    end
    set_req(0, 1'b0, 0);
    cycle("inv_idle");
`endif

    // Randomized play against the model
    start_round();
    for (int c = 0; c < 1500; c++) begin
      bus.round_start = ((m_ko != 0) && ($urandom % 4 == 0)) || ($urandom % 60 == 0);
      bus.game_active = ($urandom % 8) != 0;
      for (int p = 0; p < 2; p++) begin
        r = (p == 0) ? bus.p1_hit_req : bus.p2_hit_req;
        d = (p == 0) ? int'(bus.p1_hit_dmg) : int'(bus.p2_hit_dmg);
        if (r && m_ack[p]) begin
          r = ($urandom % 4 == 0);
          d = ($urandom % 5 == 0) ? 0 : int'($urandom_range(1, 40));
        end else if (!r && ($urandom % 3 == 0)) begin
          r = 1'b1;
          d = ($urandom % 5 == 0) ? 0 :
              ($urandom % 20 == 0) ? 255 : int'($urandom_range(1, 40));
        end
        set_req(p, r, d);
      end
      cycle("rand");
      if (c == 800) begin
        // Asynchronous reset mid-round
        #2 rst_n = 1'b0;
        #1;
        check("arst/p1HP", int'(bus.p1HP), MAX_HP);
        check("arst/p2HP", int'(bus.p2HP), MAX_HP);
        check("arst/ko",   int'(bus.ko), 0);
        check("arst/acks", int'({bus.p2_hit_ack, bus.p1_hit_ack}), 0);
        model_reset();
        #3 rst_n = 1'b1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
